// File: rtl/perceptron_introduction.sv
// Single-layer perceptron with a step activation and an on-line learning rule.
// All arithmetic is signed Q16.16 (sfp) and saturates instead of wrapping.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous, active-high reset; clears weights and bias
//   values        input vector, element i feeds lane i
//   training      1 = apply the learning rule at this edge, 0 = inference only
//   learning_rate learning rate (sfp)
//   expected      target output for the current values (sfp, normally 0 or ONE)
//   prediction    step activation of the current weighted sum (0 or ONE)

package FixedPoint;

    typedef logic signed [31:0] sfp;

    localparam sfp ONE     = 32'sh0001_0000;
    localparam sfp SFP_MAX = 32'sh7FFF_FFFF;
    localparam sfp SFP_MIN = 32'sh8000_0000;

    function automatic sfp sat_add(input sfp a, input sfp b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        // Overflow shows up as disagreement between the two top bits.
        if (s[32] != s[31]) begin
            return s[32] ? SFP_MIN : SFP_MAX;
        end
        return s[31:0];
    endfunction

    function automatic sfp sat_sub(input sfp a, input sfp b);
        logic [32:0] s;
        s = {a[31], a} - {b[31], b};
        if (s[32] != s[31]) begin
            return s[32] ? SFP_MIN : SFP_MAX;
        end
        return s[31:0];
    endfunction

    function automatic sfp fpmul(input sfp a, input sfp b);
        logic signed [63:0] p;
        logic signed [63:0] q;
        // The low 64 bits of the product are identical for signed and
        // unsigned multiplication once both operands are sign-extended.
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        q = p >>> 16;  // arithmetic shift: truncates toward -inf
        if (q > 64'sh0000_0000_7FFF_FFFF) begin
            return SFP_MAX;
        end
        if (q < $signed(64'hFFFF_FFFF_8000_0000)) begin
            return SFP_MIN;
        end
        return q[31:0];
    endfunction

endpackage

module perceptron_introduction
    import FixedPoint::*;
#(
    parameter int unsigned input_units = 2
) (
    input  logic clk,
    input  logic rst,
    input  sfp   values [input_units],
    input  logic training,
    input  sfp   learning_rate,
    input  sfp   expected,
    output sfp   prediction
);

    sfp w_q [input_units];
    sfp w_d [input_units];
    sfp b_q;
    sfp b_d;
    sfp sum;
    sfp err;
    sfp delta;

    // Combinational inference path: bias plus saturating dot product.
    always_comb begin
        sum = b_q;
        for (int unsigned i = 0; i < input_units; i++) begin
            sum = sat_add(sum, fpmul(w_q[i], values[i]));
        end
        // Strictly positive sum fires; zero stays at 0.
        prediction = (sum > 0) ? ONE : '0;
    end

    // Learning rule, driven by the prediction from the pre-edge registers.
    always_comb begin
        err   = sat_sub(expected, prediction);
        delta = fpmul(learning_rate, err);
        w_d   = w_q;
        b_d   = b_q;
        if (training) begin
            for (int unsigned i = 0; i < input_units; i++) begin
                w_d[i] = sat_add(w_q[i], fpmul(delta, values[i]));
            end
            b_d = sat_add(b_q, delta);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < input_units; i++) begin
                w_q[i] <= '0;
            end
            b_q <= '0;
        end else begin
            w_q <= w_d;
            b_q <= b_d;
        end
    end

endmodule

// File: tb/tb_perceptron_introduction.sv
// Directed self-checking bench for perceptron_introduction (input_units = 2).
// Inputs change on the falling edge; outputs and state are sampled 1 ns later.

module tb_perceptron_introduction;
    import FixedPoint::*;

    logic clk;
    logic rst;
    sfp   values [2];
    logic training;
    sfp   learning_rate;
    sfp   expected;
    sfp   prediction;

    int checks;
    int errors;

    perceptron_introduction #(.input_units(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .values       (values),
        .training     (training),
        .learning_rate(learning_rate),
        .expected     (expected),
        .prediction   (prediction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // AND gate truth table
    sfp x0_tab  [4] = '{32'sh0, 32'sh0, ONE, ONE};
    sfp x1_tab  [4] = '{32'sh0, ONE, 32'sh0, ONE};
    sfp tgt_tab [4] = '{32'sh0, 32'sh0, 32'sh0, ONE};
    // Hand-traced pre-edge predictions for epochs 1..5 with lr = ONE
    int pred_tab [5][4] = '{'{0, 0, 0, 0},
                            '{1, 1, 0, 0},
                            '{0, 1, 1, 0},
                            '{0, 0, 1, 0},
                            '{0, 1, 0, 1}};

    task automatic test_reset();
        sfp probe0 [5] = '{32'sh0001_2345, 32'shFFFF_0000, 32'sh7FFF_FFFF, ONE, 32'sh8000_0000};
        sfp probe1 [5] = '{32'shFFFE_0000, ONE, 32'sh0000_0001, ONE, 32'sh8000_0000};
        rst = 1'b1;
        training = 1'b1;
        learning_rate = ONE;
        expected = ONE;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            values[0] = probe0[c];
            values[1] = probe1[c];
            #1;
            checks++;
            if (prediction !== 32'sh0) begin
                errors++;
                $display("FAIL reset_pred cycle %0d: got %h want %h", c, prediction, 32'h0);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        training = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            values[0] = probe0[c];
            values[1] = probe1[c];
            #1;
            checks++;
            if (prediction !== 32'sh0) begin
                errors++;
                $display("FAIL post_reset_pred probe %0d: got %h want %h", c, prediction, 32'h0);
            end
        end
    endtask

    task automatic test_and_training();
        int want;
        int correct;
        learning_rate = ONE;
        for (int e = 0; e < 15; e++) begin
            for (int s = 0; s < 4; s++) begin
                @(negedge clk);
                values[0] = x0_tab[s];
                values[1] = x1_tab[s];
                expected  = tgt_tab[s];
                training  = 1'b1;
                #1;
                want = (e < 5) ? pred_tab[e][s] : ((s == 3) ? 1 : 0);
                checks++;
                if (prediction !== (want != 0 ? ONE : 32'sh0)) begin
                    errors++;
                    $display("FAIL and_train_pred epoch %0d sample %0d: got %h want %0d", e + 1, s, prediction, want);
                end
            end
            @(negedge clk);
            training = 1'b0;
            #1;
            if (e == 0) begin
                checks++;
                if (dut.w_q[0] !== ONE || dut.w_q[1] !== ONE || dut.b_q !== ONE) begin
                    errors++;
                    $display("FAIL epoch1_state: got W=(%h,%h) B=%h want W=(%h,%h) B=%h",
                             dut.w_q[0], dut.w_q[1], dut.b_q, ONE, ONE, ONE);
                end
            end
            if (e == 4 || e == 14) begin
                checks++;
                if (dut.w_q[0] !== 32'sh0002_0000 || dut.w_q[1] !== ONE || dut.b_q !== 32'shFFFE_0000) begin
                    errors++;
                    $display("FAIL converged_state epoch %0d: got W=(%h,%h) B=%h want W=(00020000,00010000) B=fffe0000",
                             e + 1, dut.w_q[0], dut.w_q[1], dut.b_q);
                end
            end
        end
        // Inference on the learned weights
        correct = 0;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            values[0] = x0_tab[s];
            values[1] = x1_tab[s];
            #1;
            checks++;
            if (prediction !== tgt_tab[s]) begin
                errors++;
                $display("FAIL and_infer sample %0d: got %h want %h", s, prediction, tgt_tab[s]);
            end else begin
                correct++;
            end
        end
        checks++;
        if (correct !== 4) begin
            errors++;
            $display("FAIL and_accuracy: got %0d/4 want 4/4", correct);
        end
    endtask

    task automatic test_inference_freeze();
        @(negedge clk);
        training  = 1'b0;
        values[0] = ONE;
        values[1] = ONE;
        expected  = 32'sh0;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (prediction !== ONE) begin
            errors++;
            $display("FAIL freeze_pred: got %h want %h", prediction, ONE);
        end
        checks++;
        if (dut.w_q[0] !== 32'sh0002_0000 || dut.w_q[1] !== ONE || dut.b_q !== 32'shFFFE_0000) begin
            errors++;
            $display("FAIL freeze_state: got W=(%h,%h) B=%h want W=(00020000,00010000) B=fffe0000",
                     dut.w_q[0], dut.w_q[1], dut.b_q);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        values[0] = ONE;
        values[1] = ONE;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (dut.w_q[0] !== 32'sh0 || dut.w_q[1] !== 32'sh0 || dut.b_q !== 32'sh0 || prediction !== 32'sh0) begin
            errors++;
            $display("FAIL async_reset: got W=(%h,%h) B=%h pred=%h want all 0",
                     dut.w_q[0], dut.w_q[1], dut.b_q, prediction);
        end
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (prediction !== 32'sh0 || dut.b_q !== 32'sh0) begin
            errors++;
            $display("FAIL async_reset_hold: got pred=%h B=%h want 0", prediction, dut.b_q);
        end
    endtask

    // Fractional delta exercises truncation toward -inf in the multiply.
    task automatic test_rounding();
        @(negedge clk);
        learning_rate = 32'sh0000_8000;
        values[0]     = 32'sh0000_0001;
        values[1]     = 32'sh0003_0000;
        expected      = 32'shFFFF_0000;
        training      = 1'b1;
        #1;
        checks++;
        if (prediction !== 32'sh0) begin
            errors++;
            $display("FAIL round_pre_pred: got %h want %h", prediction, 32'h0);
        end
        @(negedge clk);
        training = 1'b0;
        #1;
        checks++;
        if (dut.w_q[0] !== 32'shFFFF_FFFF || dut.w_q[1] !== 32'shFFFE_8000 || dut.b_q !== 32'shFFFF_8000) begin
            errors++;
            $display("FAIL round_state: got W=(%h,%h) B=%h want W=(ffffffff,fffe8000) B=ffff8000",
                     dut.w_q[0], dut.w_q[1], dut.b_q);
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        learning_rate = 32'sh7FFF_0000;
        values[0]     = 32'sh0;
        values[1]     = 32'sh0;
        expected      = ONE;
        training      = 1'b1;
        @(negedge clk);
        expected = 32'sh0002_0000;
        #1;
        checks++;
        if (dut.b_q !== 32'sh7FFF_0000 || prediction !== ONE) begin
            errors++;
            $display("FAIL sat_first: got B=%h pred=%h want B=7fff0000 pred=%h", dut.b_q, prediction, ONE);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dut.b_q !== 32'sh7FFF_FFFF) begin
            errors++;
            $display("FAIL sat_clamp: got B=%h want 7fffffff", dut.b_q);
        end
        repeat (3) @(negedge clk);
        training = 1'b0;
        #1;
        checks++;
        if (dut.b_q !== 32'sh7FFF_FFFF || prediction !== ONE || dut.w_q[0] !== 32'sh0 || dut.w_q[1] !== 32'sh0) begin
            errors++;
            $display("FAIL sat_hold: got B=%h pred=%h W=(%h,%h) want B=7fffffff pred=%h W=0",
                     dut.b_q, prediction, dut.w_q[0], dut.w_q[1], ONE);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        training      = 1'b0;
        learning_rate = '0;
        expected      = '0;
        values[0]     = '0;
        values[1]     = '0;
        test_reset();
        test_and_training();
        test_inference_freeze();
        test_async_reset();
        test_rounding();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
